// File: rtl/opcode_pkg.sv
// Shared opcode definitions for the fetch-to-decode path.
package opcode_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_0000 = 4'b0000;
  localparam logic [OPW-1:0] OP_0001 = 4'b0001;
  localparam logic [OPW-1:0] OP_0010 = 4'b0010;
  localparam logic [OPW-1:0] OP_0011 = 4'b0011;

  // Driven to the decoder whenever the FIFO holds nothing.
  localparam logic [OPW-1:0] OP_IDLE = 4'b0000;

endpackage

// File: rtl/opcode_issue_fifo.sv
// Opcode FIFO feeding the decoder: valid/ready on both sides, empty output
// masked to OP_IDLE, saturating count of issued opcodes.
module opcode_issue_fifo
  import opcode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OPW   = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [OPW-1:0]             in_opcode,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [OPW-1:0]             out_opcode,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNTW-1:0]            issued_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [OPW-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push;
  logic           pop;

  // Ready comes from registered level only; rst merely holds it low.
  assign in_ready  = ~rst & (level < LW'(DEPTH));
  assign out_valid = (level != '0);
  assign out_opcode = out_valid ? mem[rd_ptr] : OPW'(OP_IDLE);

  // A handshake coinciding with flush is discarded outright.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_count <= '0;
    end else if (pop && (issued_count != '1)) begin
      issued_count <= issued_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_opcode_issue_fifo.sv
// Directed and random stimulus for opcode_issue_fifo against a queue-based model.
module tb_opcode_issue_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OPW   = 4;
  localparam int unsigned CNTW  = 3;
  localparam int unsigned LW    = $clog2(DEPTH+1);
  localparam int          CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic [OPW-1:0]  in_opcode;
  logic            in_ready;
  logic            out_valid;
  logic [OPW-1:0]  out_opcode;
  logic            out_ready;
  logic [LW-1:0]   level;
  logic [CNTW-1:0] issued_count;

  int checks = 0;
  int errors = 0;

  logic [OPW-1:0] q [$];
  int             mcnt;

  opcode_issue_fifo #(.DEPTH(DEPTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_opcode(in_opcode),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_opcode(out_opcode),
    .out_ready(out_ready),
    .level(level),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then advance the model.
  task automatic step(input logic iv, input logic [OPW-1:0] op, input logic ordy,
                      input logic fl, input logic r);
    logic exp_ready;
    logic do_pop;
    in_valid  = iv;
    in_opcode = op;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    exp_ready = !r && (q.size() < DEPTH);
    chk("level", 32'(level), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_opcode", 32'(out_opcode), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("issued_count", 32'(issued_count), 32'(mcnt));
    if (r) begin
      q.delete();
      mcnt = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      do_pop = (q.size() != 0) && ordy;
      if (do_pop) begin
        void'(q.pop_front());
        if (mcnt < CMAX) mcnt++;
      end
      if (iv && exp_ready) q.push_back(op);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_opcode = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    mcnt = 0;
    q.delete();

    // Reset then idle
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Fill and drain
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Full with simultaneous pop: push refused, freed slot visible next cycle
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 8), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Wrap-around streaming, also saturates the 3-bit counter
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i % 16), 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Flush collision at level 2
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Saturation then reset mid-stream with traffic and flush asserted
    for (int i = 0; i < 12; i++) step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b1, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opcode_issue_fifo.md
Name: opcode_issue_fifo

Overview:
- Buffering stage directly upstream of the opcode decoder.
- Accepts 4-bit opcodes from the fetch side over a valid/ready handshake and holds up to DEPTH entries.
- Presents the oldest entry to the decoder with its own valid/ready handshake.
- Guarantees the decoder never sees an undriven (X) opcode: the output is forced to 4'b0000 when the FIFO is empty.

Parameters:
- DEPTH, 4, number of opcode entries (any integer >= 2).
- OPW, 4, opcode width in bits (the decoder requires 4).
- CNTW, 8, width of the saturating issued-opcode counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream opcode valid.
- in_opcode  input  OPW  upstream opcode.
- in_ready  output  1  FIFO can accept an opcode this cycle.
- out_valid  output  1  out_opcode holds a buffered entry.
- out_opcode  output  OPW  oldest buffered opcode; feeds the decoder.
- out_ready  input  1  decoder/consumer takes the entry this cycle.
- level  output  $clog2(DEPTH+1)  current entry count.
- issued_count  output  CNTW  number of opcodes popped since reset, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: level=0, out_valid=0, out_opcode=4'b0000, in_ready=1 (from the cycle after reset deasserts), issued_count=0. Read and write pointers are 0.
- While rst is high, in_ready=0; no push or pop occurs.
- Push: occurs when in_valid && in_ready. in_opcode is written at wr_ptr and wr_ptr advances.
- Pop: occurs when out_valid && out_ready. rd_ptr advances.
- in_ready = (level < DEPTH). It depends only on registered state, so there is no combinational path from out_ready to in_ready. When full with a simultaneous pop, in_ready stays 0; the freed slot is visible next cycle.
- out_valid = (level != 0).
- out_opcode = mem[rd_ptr] when out_valid, else 4'b0000. It is a combinational mux of registered storage only.
- Latency: an opcode pushed in cycle N is visible on out_opcode/out_valid in cycle N+1 at the earliest. There is no same-cycle bypass.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- Simultaneous push and pop when 0 < level < DEPTH: level is unchanged and both pointers advance.
- Push and pop when level==0: a pop is impossible (out_valid=0), so only the push takes effect.
- Pointer wrap: each pointer goes from DEPTH-1 to 0 explicitly (not by modulo truncation), so non-power-of-two DEPTH is legal.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- flush:
  - Takes priority over a push or pop in the same cycle.
  - Next cycle: level=0, pointers=0, out_valid=0, out_opcode=0.
  - A handshake that coincides with flush is discarded. issued_count does NOT increment for it.
  - issued_count is not cleared by flush, only by rst.
- issued_count increments by 1 per pop and saturates at 2^CNTW-1; it never wraps.
- rst mid-operation: all buffered entries are lost and outputs return to reset values in the following cycle, regardless of flush, in_valid or out_ready.
- Storage contents are not reset. Only the pointers and level are reset; out_opcode masking prevents stale or X data from reaching the decoder.

Decomposition:
- Shared package (opcode_pkg):
  - localparam OPW=4.
  - Opcode constants OP_0000..OP_0011 matching the decoder's explicit arms.
  - OP_IDLE=4'b0000, the value driven when empty.
- No sub-module is needed. Storage, pointers, level and counter fit in one module (~150 lines).
- A separate sat_counter sub-module is allowed but not required.

Test Plan:
- Reset then idle: after rst high for 2 cycles and then low -> level=0, out_valid=0, out_opcode=4'b0000, in_ready=1, issued_count=0.
- Fill and drain: push 0001,0010,0011,0000 with out_ready=0 -> level=4 and in_ready=0. Then out_ready=1 for 4 cycles -> out_opcode sequence 0001,0010,0011,0000, then out_valid=0, out_opcode=0000, issued_count=4.
- Full with simultaneous pop: at level=4, in_valid=1 and out_ready=1 -> push refused, level=3 next cycle. in_ready=1 the cycle after that, and the push is then accepted.
- Wrap-around streaming: in_valid=1 and out_ready=1 continuously for 10 opcodes 0..9 mod 16 -> outputs in identical order with 1-cycle latency, level holding at 1, pointers wrapping twice.
- Flush collision: at level=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, issued_count unchanged, and the pushed opcode is never emitted.
- Counter saturation: with CNTW=3, perform 10 pops -> issued_count reads 7 and stays at 7. Asserting rst mid-stream returns it to 0.
